bram_arbiter: RTL and testbench

//  Two-port arbiter sharing one single-port bram (1-cycle registered read, per-byte wmask)

---
 rtl/bram_arbiter.sv | 114 +++++++++++
 tb/tb_bram_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for one single-port bram (registered read, byte mask).
// Ports: clk/resetn, r0_*/r1_* valid/ready requesters, mem_* bram side.
// Optional: BRAM_ARB_FIXED_PRIO_EN gives r0 fixed priority (default round-robin).
module bram_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             r0_valid,
  input  logic [31:0]      r0_addr,
  input  logic [31:0]      r0_wdata,
  input  logic [3:0]       r0_wstrb,
  output logic             r0_ready,
  output logic [31:0]      r0_rdata,
  input  logic             r1_valid,
  input  logic [31:0]      r1_addr,
  input  logic [31:0]      r1_wdata,
  input  logic [3:0]       r1_wstrb,
  output logic             r1_ready,
  output logic [31:0]      r1_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] addr_q, addr_d;

  logic             winner;
  logic             g_valid;
  logic [31:0]      g_addr;
  logic [31:0]      g_wdata;
  logic [3:0]       g_wstrb;

  assign g_valid = grant_q ? r1_valid : r0_valid;
  assign g_addr  = grant_q ? r1_addr  : r0_addr;
  assign g_wdata = grant_q ? r1_wdata : r0_wdata;
  assign g_wstrb = grant_q ? r1_wstrb : r0_wstrb;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign winner = ~r0_valid;
`else
  // Tie goes to the side that was not served last.
  assign winner = (r0_valid & r1_valid) ? ~last_q : r1_valid;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    mem_wmask = 4'h0;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_valid | r1_valid) begin
          grant_d = winner;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A write commits here even if valid was withdrawn.
        addr_d    = g_addr[WIDTH+1:2];
        mem_wmask = g_wstrb;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`else
        last_d    = grant_q;
`endif
        state_d   = RESP;
      end
      RESP: begin
        r0_ready = g_valid & ~grant_q;
        r1_ready = g_valid &  grant_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_d;
  assign mem_wdata = g_wdata;
  assign r0_rdata  = r0_ready ? mem_rdata : 32'h0;
  assign r1_rdata  = r1_ready ? mem_rdata : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{r0_addr[31:WIDTH+2], r0_addr[1:0],
                              r1_addr[31:WIDTH+2], r1_addr[1:0]};

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter.
// Includes a behavioural bram with registered, read-before-write output.
module tb_bram_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             r0_valid = 1'b0, r1_valid = 1'b0;
  logic [31:0]      r0_addr = '0, r1_addr = '0;
  logic [31:0]      r0_wdata = '0, r1_wdata = '0;
  logic [3:0]       r0_wstrb = '0, r1_wstrb = '0;
  logic             r0_ready, r1_ready;
  logic [31:0]      r0_rdata, r1_rdata;
  logic [WIDTH-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wmask;
  logic [31:0]      mem_rdata = '0;

  logic [31:0] mem [1<<WIDTH];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_wstrb(r0_wstrb), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_wstrb(r1_wstrb), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on port p, wait (bounded) for ready, drop valid.
  task automatic xfer(input int p, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int lat);
    if (p == 0) begin
      r0_valid = 1; r0_addr = a; r0_wdata = wd; r0_wstrb = ws;
    end else begin
      r1_valid = 1; r1_addr = a; r1_wdata = wd; r1_wstrb = ws;
    end
    lat = 0;
    while (!(p == 0 ? r0_ready : r1_ready) && lat < 10) begin
      step();
      lat++;
    end
    rd = (p == 0) ? r0_rdata : r1_rdata;
    r0_valid = 0; r1_valid = 0;
    r0_wstrb = 0; r1_wstrb = 0;
    step();
  endtask

  logic [31:0] rd;
  int lat;
  int cnt;
  logic [31:0] exp_g;

  initial begin
    for (int i = 0; i < (1 << WIDTH); i++) mem[i] = 32'h0;

    // Reset held with both requesters asking for writes
    r0_valid = 1; r0_addr = 32'h8; r0_wdata = 32'hFFFF_FFFF; r0_wstrb = 4'hF;
    r1_valid = 1; r1_addr = 32'hC; r1_wdata = 32'hFFFF_FFFF; r1_wstrb = 4'hF;
    repeat (4) step();
    check("rst_r0_ready", {31'b0, r0_ready}, 32'h0);
    check("rst_r1_ready", {31'b0, r1_ready}, 32'h0);
    check("rst_wmask", {28'b0, mem_wmask}, 32'h0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
    check("rst_no_write", mem[2] | mem[3], 32'h0);
    r0_valid = 0; r1_valid = 0; r0_wstrb = 0; r1_wstrb = 0;
    step();
    resetn = 1;
    step();

    // Contention: both held high for six accesses
    r0_valid = 1; r0_addr = 32'h40;
    r1_valid = 1; r1_addr = 32'h44;
    for (int k = 0; k < 6; k++) begin
      cnt = 0;
      while (!(r0_ready | r1_ready) && cnt < 10) begin
        step();
        cnt++;
      end
`ifdef BRAM_ARB_FIXED_PRIO_EN
      exp_g = 32'h0;
`else
      exp_g = k % 2;
`endif
      check($sformatf("arb_grant%0d", k), {31'b0, r1_ready}, exp_g);
      check($sformatf("arb_one_hot%0d", k), {31'b0, r0_ready ^ r1_ready}, 32'h1);
      if (k == 5) begin
        r0_valid = 0; r1_valid = 0;
      end
      step();
    end
    step();

    // r0 full-word write, cycle by cycle
    r0_valid = 1; r0_addr = 32'h10; r0_wdata = 32'hDEAD_BEEF; r0_wstrb = 4'hF;
    step();
    check("wr_mem_addr", {24'b0, mem_addr}, 32'h4);
    check("wr_wmask", {28'b0, mem_wmask}, 32'hF);
    check("wr_no_ready_early", {31'b0, r0_ready}, 32'h0);
    step();
    check("wr_r0_ready", {31'b0, r0_ready}, 32'h1);
    check("wr_r1_idle", {31'b0, r1_ready}, 32'h0);
    check("wr_r1_rdata0", r1_rdata, 32'h0);
    check("wr_resp_wmask", {28'b0, mem_wmask}, 32'h0);
    r0_valid = 0; r0_wstrb = 0;
    step();
    check("wr_ready_pulse", {31'b0, r0_ready}, 32'h0);
    check("wr_rdata_idle", r0_rdata, 32'h0);
    check("wr_addr_hold", {24'b0, mem_addr}, 32'h4);
    xfer(1, 32'h10, 32'h0, 4'h0, rd, lat);
    check("rd_r1_data", rd, 32'hDEAD_BEEF);
    check("rd_r1_latency", lat, 2);

    // Byte write: old word comes back, merge visible on re-read
    xfer(1, 32'h10, 32'h00AA_0000, 4'b0100, rd, lat);
    check("bw_old_data", rd, 32'hDEAD_BEEF);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, lat);
    check("bw_merged", rd, 32'hDEAA_BEEF);

    // Address wrap modulo depth
    xfer(0, 32'h400, 32'h1234_5678, 4'hF, rd, lat);
    check("wrap_word0", mem[0], 32'h1234_5678);
    xfer(1, 32'h0, 32'h0, 4'h0, rd, lat);
    check("wrap_read0", rd, 32'h1234_5678);

    // Valid withdrawn during ACCESS: write lands, no ready
    r1_valid = 1; r1_addr = 32'h20; r1_wdata = 32'hCAFE_F00D; r1_wstrb = 4'hF;
    step();
    r1_valid = 0;
    #1;
    check("abort_wmask", {28'b0, mem_wmask}, 32'hF);
    step();
    check("abort_no_ready", {31'b0, r1_ready}, 32'h0);
    check("abort_rdata0", r1_rdata, 32'h0);
    r1_wstrb = 0;
    step();
    check("abort_committed", mem[8], 32'hCAFE_F00D);
    xfer(0, 32'h20, 32'h0, 4'h0, rd, lat);
    check("abort_back_idle", lat, 2);
    check("abort_readback", rd, 32'hCAFE_F00D);

    // Reset pulse in ACCESS kills the write
    r0_valid = 1; r0_addr = 32'h20; r0_wdata = 32'h1111_1111; r0_wstrb = 4'hF;
    step();
    check("rstacc_wmask_on", {28'b0, mem_wmask}, 32'hF);
    resetn = 0;
    #1;
    check("rstacc_wmask_off", {28'b0, mem_wmask}, 32'h0);
    r0_valid = 0; r0_wstrb = 0;
    step();
    check("rstacc_no_ready", {31'b0, r0_ready}, 32'h0);
    check("rstacc_mem_kept", mem[8], 32'hCAFE_F00D);
    resetn = 1;
    step();
    xfer(1, 32'h20, 32'h0, 4'h0, rd, lat);
    check("rstacc_recover", rd, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
